sequential_normalizer: RTL and testbench
========================================

SEQUENTIAL_NORMALIZER -- requirements
Module: sequential_normalizer

Interface
REQ-001 The module SHALL have no parameters; data width is fixed at 16 bits and count width at 4 bits.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Start  input  1  request to normalize A; sampled on the rising edge of clk.
REQ-005 Dir  input  1  sampled with Start; 1 = left-normalize (remove leading zeros), 0 = right-normalize (remove trailing zeros).
REQ-006 A  input  [16:1]  operand; sampled with Start.
REQ-007 Out  output  [16:1]  normalized result.
REQ-008 Count  output  [4:1]  number of bit positions shifted.
REQ-009 Zero  output  1  operand was all-zero.
REQ-010 Busy  output  1  high while an operation is in progress.
REQ-011 Done  output  1  one-cycle pulse; Out, Count and Zero are valid.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 IDLE or DONE with Start=1: latch A into the work register and Dir, clear Count, go to SHIFT; Start=0: go to or stay in IDLE.
REQ-014 SHIFT with work==0: set Zero=1, Count=0, go to DONE.
REQ-015 SHIFT, Dir=1: work[16]=1 -> go to DONE; else shift work left 1 with zero fill, Count+1, stay in SHIFT.
REQ-016 SHIFT, Dir=0: work[1]=1 -> go to DONE; else shift work right 1 with zero fill, Count+1, stay in SHIFT.
REQ-017 For nonzero operands Count SHALL never exceed 15 and SHALL never wrap.
REQ-018 Out SHALL equal the work register; Out, Count and Zero SHALL hold from DONE until the next accepted Start.
REQ-019 Busy SHALL be 1 exactly when the state is SHIFT; Done SHALL be 1 exactly when the state is DONE.
REQ-020 Start in SHIFT SHALL be ignored, with no effect on the operation in progress.
REQ-021 Latency from the Start sampling edge to Done high SHALL be S+2 cycles, where S is the number of shift steps (zero operand: S=0).
REQ-022 Back-to-back operation: Start asserted during DONE SHALL be accepted, so Done pulses are separated by S+2 cycles.

Reset
REQ-023 rst_n=0 SHALL immediately force: state IDLE; Out, work register, Count, Zero, Busy and Done to 0; latched Dir to 0.
REQ-024 Reset asserted mid-operation SHALL abort the operation with no Done pulse.
REQ-025 The first Start after rst_n deasserts SHALL be accepted on the first rising edge at which it is sampled high.

Configuration
REQ-026 Macro NORM_NIBBLE_SKIP_EN: when defined, a SHIFT cycle whose leading nibble (Dir=1: work[16:13]; Dir=0: work[4:1]) is zero on a nonzero work value SHALL shift 4 bits and add 4 to Count.
REQ-027 Without NORM_NIBBLE_SKIP_EN, every shift step SHALL be exactly one bit.
REQ-028 Final Out, Count and Zero SHALL be identical with and without the macro; only S and latency differ.

Verification
REQ-029 Dir=1, A=16'b1011001001010010, Start pulse -> Done at +2 cycles, Out=A, Count=0, Zero=0.
REQ-030 Dir=1, A=16'h0013 -> Out=16'h9800, Count=11, Zero=0; Done at +13 cycles without the macro, +7 with it (4,4,1,1,1).
REQ-031 Dir=0, A=16'b1011001001010000 -> Out=16'h0B25, Count=4; Done at +6 cycles without the macro, +3 with it.
REQ-032 A=16'h0000, either Dir -> Zero=1, Count=0, Out=0, Done at +2 cycles.
REQ-033 Dir=1, A=16'h0001, Start re-pulsed with A=16'hFFFF while Busy -> second Start ignored; Out=16'h8000, Count=15.
REQ-034 rst_n pulsed low during SHIFT of A=16'h0001 -> all outputs 0 at once, no Done; a new Start afterwards completes normally.

Source files
------------

// File: rtl/sequential_normalizer.sv
// Iterative 16-bit normalizer: strips leading (Dir=1) or trailing (Dir=0) zeros one step per cycle.
// Optional NORM_NIBBLE_SKIP_EN: skip a whole zero nibble per cycle; final results are unchanged.
module sequential_normalizer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic        Dir,
    input  logic [16:1] A,
    output logic [16:1] Out,
    output logic [4:1]  Count,
    output logic        Zero,
    output logic        Busy,
    output logic        Done
);

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]    state, state_next;
    logic [DW:1]   work, work_next;
    logic [CW:1]   count_next;
    logic          zero_next;
    logic          dir_q, dir_next;

    // Next-state and datapath update
    always_comb begin
        state_next = state;
        work_next  = work;
        count_next = Count;
        zero_next  = Zero;
        dir_next   = dir_q;
        case (state)
            IDLE, DONE: begin
                if (Start) begin
                    work_next  = A;
                    dir_next   = Dir;
                    count_next = '0;
                    zero_next  = 1'b0;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                if (work == '0) begin
                    zero_next  = 1'b1;
                    count_next = '0;
                    state_next = DONE;
                end else if (dir_q) begin
                    if (work[16]) begin
                        state_next = DONE;
`ifdef NORM_NIBBLE_SKIP_EN
                    end else if (work[16:13] == 4'b0000) begin
                        work_next  = {work[12:1], 4'b0000};
                        count_next = Count + CW'(4);
`endif
                    end else begin
                        work_next  = {work[15:1], 1'b0};
                        count_next = Count + CW'(1);
                    end
                end else begin
                    if (work[1]) begin
                        state_next = DONE;
`ifdef NORM_NIBBLE_SKIP_EN
                    end else if (work[4:1] == 4'b0000) begin
                        work_next  = {4'b0000, work[16:5]};
                        count_next = Count + CW'(4);
`endif
                    end else begin
                        work_next  = {1'b0, work[16:2]};
                        count_next = Count + CW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers; Busy/Done track the next state so they equal the state decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            work  <= '0;
            Count <= '0;
            Zero  <= 1'b0;
            dir_q <= 1'b0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
        end else begin
            state <= state_next;
            work  <= work_next;
            Count <= count_next;
            Zero  <= zero_next;
            dir_q <= dir_next;
            Busy  <= (state_next == SHIFT);
            Done  <= (state_next == DONE);
        end
    end

    assign Out = work;

endmodule

// File: tb/tb_sequential_normalizer.sv
// Self-checking bench for sequential_normalizer: directed table, corner sequences and random ops
// checked against an arithmetic reference model (honours NORM_NIBBLE_SKIP_EN for latency).
module tb_sequential_normalizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Start;
    logic        Dir;
    logic [15:0] A;
    logic [15:0] Out;
    logic [3:0]  Count;
    logic        Zero;
    logic        Busy;
    logic        Done;

    int tests  = 0;
    int failed = 0;

    sequential_normalizer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Start (Start),
        .Dir   (Dir),
        .A     (A),
        .Out   (Out),
        .Count (Count),
        .Zero  (Zero),
        .Busy  (Busy),
        .Done  (Done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dir;
        logic [15:0] a;
        logic [15:0] out;
        logic [3:0]  cnt;
        logic        zero;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: position of the extreme set bit gives the shift distance directly
    function automatic void model(input logic d, input logic [15:0] a,
                                  output logic [15:0] o, output int n, output logic z);
        bit found;
        n = 0;
        found = 0;
        z = (a == 16'h0000);
        if (d) begin
            for (int p = 15; p >= 0; p--)
                if (!found && a[p]) begin n = 15 - p; found = 1; end
            o = a << n;
        end else begin
            for (int p = 0; p < 16; p++)
                if (!found && a[p]) begin n = p; found = 1; end
            o = a >> n;
        end
    endfunction

    function automatic int model_lat(input int n);
`ifdef NORM_NIBBLE_SKIP_EN
        return (n / 4) + (n % 4) + 2;
`else
        return n + 2;
`endif
    endfunction

    // Issue one op from the current (off-edge) time; lat = cycle index of Done, -1 on timeout
    task automatic run_op(input logic d, input logic [15:0] a, output int lat, output bit busy_bad);
        lat = -1;
        busy_bad = 0;
        Start = 1'b1; Dir = d; A = a;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin Start = 1'b0; Dir = ~d; A = ~a; end
            if (Done) begin
                lat = i;
                if (Busy) busy_bad = 1;
                break;
            end
            if (!Busy) busy_bad = 1;
        end
    endtask

    task automatic check_op(input string name, input logic d, input logic [15:0] a);
        logic [15:0] eo;
        int          en;
        logic        ez;
        int          lat;
        bit          bb;
        model(d, a, eo, en, ez);
        run_op(d, a, lat, bb);
        check({name, ".lat"},   32'(lat), 32'(model_lat(en)));
        check({name, ".out"},   32'(Out), 32'(eo));
        check({name, ".count"}, 32'(Count), 32'(en));
        check({name, ".zero"},  32'(Zero), 32'(ez));
        check({name, ".busy"},  32'(bb), 32'(0));
    endtask

    initial begin
        vec_t        vecs[8];
        int          lat;
        int          k;
        bit          bb;
        logic        d;
        logic [15:0] a;
        logic [15:0] hold_out;
        logic [3:0]  hold_cnt;
        logic        hold_zero;

        vecs[0] = '{1'b1, 16'b1011001001010010, 16'b1011001001010010, 4'd0,  1'b0};
        vecs[1] = '{1'b1, 16'h0013, 16'h9800, 4'd11, 1'b0};
        vecs[2] = '{1'b0, 16'b1011001001010000, 16'h0B25, 4'd4,  1'b0};
        vecs[3] = '{1'b1, 16'h0000, 16'h0000, 4'd0,  1'b1};
        vecs[4] = '{1'b0, 16'h0000, 16'h0000, 4'd0,  1'b1};
        vecs[5] = '{1'b1, 16'h0001, 16'h8000, 4'd15, 1'b0};
        vecs[6] = '{1'b0, 16'h8000, 16'h0001, 4'd15, 1'b0};
        vecs[7] = '{1'b0, 16'hFFFF, 16'hFFFF, 4'd0,  1'b0};

        rst_n = 1'b0; Start = 1'b0; Dir = 1'b0; A = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset.out",   32'(Out), 32'(0));
        check("reset.count", 32'(Count), 32'(0));
        check("reset.zero",  32'(Zero), 32'(0));
        check("reset.busy",  32'(Busy), 32'(0));
        check("reset.done",  32'(Done), 32'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table (back-to-back: each op starts in the previous DONE cycle)
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].dir, vecs[i].a, lat, bb);
            check($sformatf("vec%0d.lat", i),   32'(lat), 32'(model_lat(int'(vecs[i].cnt))));
            check($sformatf("vec%0d.out", i),   32'(Out), 32'(vecs[i].out));
            check($sformatf("vec%0d.count", i), 32'(Count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d.zero", i),  32'(Zero), 32'(vecs[i].zero));
            check($sformatf("vec%0d.busy", i),  32'(bb), 32'(0));
        end

        // Results hold in IDLE and Done is a single-cycle pulse
        hold_out = Out; hold_cnt = Count; hold_zero = Zero;
        repeat (3) @(posedge clk);
        #1;
        check("hold.out",   32'(Out), 32'(hold_out));
        check("hold.count", 32'(Count), 32'(hold_cnt));
        check("hold.zero",  32'(Zero), 32'(hold_zero));
        check("hold.done",  32'(Done), 32'(0));
        check("hold.busy",  32'(Busy), 32'(0));

        // Start re-pulsed while busy must be ignored
        Start = 1'b1; Dir = 1'b1; A = 16'h0001;
        @(posedge clk); #1;
        Start = 1'b0;
        @(posedge clk); #1;
        check("ignore.busy", 32'(Busy), 32'(1));
        Start = 1'b1; Dir = 1'b0; A = 16'hFFFF;
        @(posedge clk); #1;
        Start = 1'b0;
        lat = -1;
        if (Done) lat = 3;
        for (int i = 4; i <= 60 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (Done) lat = i;
        end
        check("ignore.lat",   32'(lat), 32'(model_lat(15)));
        check("ignore.out",   32'(Out), 32'(16'h8000));
        check("ignore.count", 32'(Count), 32'(15));
        check("ignore.zero",  32'(Zero), 32'(0));
        @(posedge clk); #1;

        // Asynchronous reset mid-operation aborts with no Done
        Start = 1'b1; Dir = 1'b1; A = 16'h0001;
        @(posedge clk); #1;
        Start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort.out",   32'(Out), 32'(0));
        check("abort.count", 32'(Count), 32'(0));
        check("abort.zero",  32'(Zero), 32'(0));
        check("abort.busy",  32'(Busy), 32'(0));
        check("abort.done",  32'(Done), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        bb = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (Done || Busy) bb = 1;
        end
        check("abort.quiet", 32'(bb), 32'(0));
        check_op("after_abort", 1'b1, 16'h0001);

        // Random operations against the reference model
        for (int t = 0; t < 40; t++) begin
            d = 1'($urandom_range(0, 1));
            k = int'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: a = 16'h0000;
                1: a = 16'h0001 << k;
                2: a = 16'($urandom);
                default: a = d ? (16'($urandom) >> k) : (16'($urandom) << k);
            endcase
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            check_op($sformatf("rand%0d", t), d, a);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
